// File: rtl/butterfly_pkg.sv
// Shared types, widths and result reduction for the butterfly datapath.
// BUTTERFLY_SAT_EN selects clamping instead of wrap on y/z reduction.
package butterfly_pkg;

  localparam int N      = 8;
  localparam int W_BW   = N + 2;
  localparam int W_SUM  = N + 3;
  localparam int W_PSUM = 2 * N + 1;

  typedef enum logic [1:0] {
    SEL_REY,
    SEL_IMY,
    SEL_REZ,
    SEL_IMZ
  } sel_t;

  localparam logic signed [W_SUM-1:0] S_MAX =
    W_SUM'((1 <<< (N - 1)) - 1);
  localparam logic signed [W_SUM-1:0] S_MIN =
    -W_SUM'(1 <<< (N - 1));

  function automatic logic fits(
    input logic signed [W_SUM-1:0] v
  );
    return (v >= S_MIN) && (v <= S_MAX);
  endfunction

  function automatic logic [N-1:0] reduce(
    input logic signed [W_SUM-1:0] v
  );
    logic signed [W_SUM-1:0] r;
    r = v;
`ifdef BUTTERFLY_SAT_EN
    if (v > S_MAX) r = S_MAX;
    else if (v < S_MIN) r = S_MIN;
`endif
    return r[N-1:0];
  endfunction

endpackage

// File: rtl/butterfly_datapath_if.sv
// Strobe, operand and display bus between sequencer and butterfly.
// master: sequencer side; slave: datapath side (drives out, ovf).
interface butterfly_datapath_if;
  import butterfly_pkg::*;

  logic [N-1:0] sw;
  logic         load_Rew;
  logic         load_Imw;
  logic         load_Reb;
  logic         load_Imb;
  logic         load_Rea;
  logic         load_Ima;
  logic         mul_en;
  logic         cal_en;
  logic         display_Rey;
  logic         display_Imy;
  logic         display_Rez;
  logic         display_Imz;
  logic [N-1:0] out;
  logic         ovf;

  modport master (
    output sw,
    output load_Rew, load_Imw,
    output load_Reb, load_Imb,
    output load_Rea, load_Ima,
    output mul_en, cal_en,
    output display_Rey, display_Imy,
    output display_Rez, display_Imz,
    input  out, ovf
  );

  modport slave (
    input  sw,
    input  load_Rew, load_Imw,
    input  load_Reb, load_Imb,
    input  load_Rea, load_Ima,
    input  mul_en, cal_en,
    input  display_Rey, display_Imy,
    input  display_Rez, display_Imz,
    output out, ovf
  );

endinterface

// File: rtl/butterfly_datapath_cmul.sv
// Complex product b*w with w in Q1.(N-1), floored, registered on en.
// Ports: clk, Rst, en, reb/imb/rew/imw in; bw_re/bw_im (N+2) out.
module cmul
  import butterfly_pkg::*;
(
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   en,
  input  logic signed [N-1:0]    reb,
  input  logic signed [N-1:0]    imb,
  input  logic signed [N-1:0]    rew,
  input  logic signed [N-1:0]    imw,
  output logic signed [W_BW-1:0] bw_re,
  output logic signed [W_BW-1:0] bw_im
);

  logic signed [W_PSUM-1:0] p_re;
  logic signed [W_PSUM-1:0] p_im;

  assign p_re = W_PSUM'(reb) * W_PSUM'(rew)
              - W_PSUM'(imb) * W_PSUM'(imw);
  assign p_im = W_PSUM'(reb) * W_PSUM'(imw)
              + W_PSUM'(imb) * W_PSUM'(rew);

  // >>> on a signed value floors; the N+2 low bits of the
  // shifted sum hold every reachable value.
  always_ff @(posedge clk) begin
    if (Rst) begin
      bw_re <= '0;
      bw_im <= '0;
    end else if (en) begin
      bw_re <= W_BW'(p_re >>> (N - 1));
      bw_im <= W_BW'(p_im >>> (N - 1));
    end
  end

endmodule

// File: rtl/butterfly_datapath.sv
// Radix-2 butterfly: y = a + b*w, z = a - b*w, one component shown.
// Ports: clk, Rst, bus (slave). Wrap/clamp set by BUTTERFLY_SAT_EN.
module butterfly_datapath
  import butterfly_pkg::*;
(
  input  logic                 clk,
  input  logic                 Rst,
  butterfly_datapath_if.slave  bus
);

  logic signed [N-1:0]    rew, imw, reb, imb, rea, ima;
  logic signed [W_BW-1:0] bw_re, bw_im;
  logic        [N-1:0]    y_re, y_im, z_re, z_im;
  logic        [N-1:0]    out_q;
  logic                   ovf_q;

  logic signed [W_SUM-1:0] sy_re, sy_im, sz_re, sz_im;
  sel_t                    sel;
  logic                    disp;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rew <= '0;
      imw <= '0;
      reb <= '0;
      imb <= '0;
      rea <= '0;
      ima <= '0;
    end else begin
      if (bus.load_Rew) rew <= bus.sw;
      if (bus.load_Imw) imw <= bus.sw;
      if (bus.load_Reb) reb <= bus.sw;
      if (bus.load_Imb) imb <= bus.sw;
      if (bus.load_Rea) rea <= bus.sw;
      if (bus.load_Ima) ima <= bus.sw;
    end
  end

  cmul u_cmul (
    .clk   (clk),
    .Rst   (Rst),
    .en    (bus.mul_en),
    .reb   (reb),
    .imb   (imb),
    .rew   (rew),
    .imw   (imw),
    .bw_re (bw_re),
    .bw_im (bw_im)
  );

  assign sy_re = W_SUM'(rea) + W_SUM'(bw_re);
  assign sy_im = W_SUM'(ima) + W_SUM'(bw_im);
  assign sz_re = W_SUM'(rea) - W_SUM'(bw_re);
  assign sz_im = W_SUM'(ima) - W_SUM'(bw_im);

  always_ff @(posedge clk) begin
    if (Rst) begin
      y_re  <= '0;
      y_im  <= '0;
      z_re  <= '0;
      z_im  <= '0;
      ovf_q <= 1'b0;
    end else if (bus.cal_en) begin
      y_re  <= reduce(sy_re);
      y_im  <= reduce(sy_im);
      z_re  <= reduce(sz_re);
      z_im  <= reduce(sz_im);
      ovf_q <= !(fits(sy_re) && fits(sy_im)
              && fits(sz_re) && fits(sz_im));
    end
  end

  // Strobes may overlap; first match wins.
  always_comb begin
    sel  = SEL_REY;
    disp = bus.display_Rey | bus.display_Imy
         | bus.display_Rez | bus.display_Imz;
    priority case (1'b1)
      bus.display_Rey: sel = SEL_REY;
      bus.display_Imy: sel = SEL_IMY;
      bus.display_Rez: sel = SEL_REZ;
      bus.display_Imz: sel = SEL_IMZ;
      default:         sel = SEL_REY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      out_q <= '0;
    end else if (disp) begin
      unique case (sel)
        SEL_REY: out_q <= y_re;
        SEL_IMY: out_q <= y_im;
        SEL_REZ: out_q <= z_re;
        SEL_IMZ: out_q <= z_im;
      endcase
    end
  end

  assign bus.out = out_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_butterfly_datapath.sv
// Directed-vector bench for butterfly_datapath.
// Expected values are hand-computed for N=8.
module tb_butterfly_datapath;
  import butterfly_pkg::*;

  logic clk = 1'b0;
  logic Rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   v;

  butterfly_datapath_if bus ();

  butterfly_datapath dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.load_Rew    = 1'b0;
    bus.load_Imw    = 1'b0;
    bus.load_Reb    = 1'b0;
    bus.load_Imb    = 1'b0;
    bus.load_Rea    = 1'b0;
    bus.load_Ima    = 1'b0;
    bus.mul_en      = 1'b0;
    bus.cal_en      = 1'b0;
    bus.display_Rey = 1'b0;
    bus.display_Imy = 1'b0;
    bus.display_Rez = 1'b0;
    bus.display_Imz = 1'b0;
  endtask

  task automatic ld(input int idx, input int val);
    logic [31:0] t;
    t = val;
    bus.sw = t[N-1:0];
    case (idx)
      0: bus.load_Rew = 1'b1;
      1: bus.load_Imw = 1'b1;
      2: bus.load_Reb = 1'b1;
      3: bus.load_Imb = 1'b1;
      4: bus.load_Rea = 1'b1;
      default: bus.load_Ima = 1'b1;
    endcase
    tick();
    clr();
  endtask

  task automatic run_vec(input int wr, input int wi,
                         input int br, input int bi,
                         input int ar, input int ai);
    ld(0, wr); ld(1, wi); ld(2, br);
    ld(3, bi); ld(4, ar); ld(5, ai);
    bus.mul_en = 1'b1; tick(); clr();
    bus.cal_en = 1'b1; tick(); clr();
  endtask

  task automatic show(input int idx, output int o);
    case (idx)
      0: bus.display_Rey = 1'b1;
      1: bus.display_Imy = 1'b1;
      2: bus.display_Rez = 1'b1;
      default: bus.display_Imz = 1'b1;
    endcase
    tick();
    clr();
    o = int'($signed(bus.out));
  endtask

  initial begin
    int exp_y3;
`ifdef BUTTERFLY_SAT_EN
    exp_y3 = 127;
`else
    exp_y3 = -30;
`endif
    clr();
    bus.sw = '0;
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    chk("rst_out", int'($signed(bus.out)), 0);
    chk("rst_ovf", int'(bus.ovf), 0);

    run_vec(64, 0, 40, -20, 10, 5);
    chk("v1_ovf", int'(bus.ovf), 0);
    show(0, v); chk("v1_yre", v, 30);
    show(1, v); chk("v1_yim", v, -5);
    show(2, v); chk("v1_zre", v, -10);
    show(3, v); chk("v1_zim", v, 15);

    bus.display_Rey = 1'b1;
    bus.display_Imz = 1'b1;
    tick(); clr();
    chk("prio_rey", int'($signed(bus.out)), 30);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_out", int'($signed(bus.out)), 30);

    run_vec(0, 64, 40, -20, 0, 0);
    show(0, v); chk("v2_yre", v, 10);
    show(1, v); chk("v2_yim", v, 20);
    show(2, v); chk("v2_zre", v, -10);
    show(3, v); chk("v2_zim", v, -20);

    run_vec(64, 0, -1, 0, 0, 0);
    chk("v4_ovf", int'(bus.ovf), 0);
    show(0, v); chk("v4_yre", v, -1);
    show(2, v); chk("v4_zre", v, 1);

    run_vec(127, 0, 127, 0, 100, 0);
    chk("v3_ovf", int'(bus.ovf), 1);
    show(0, v); chk("v3_yre", v, exp_y3);
    show(2, v); chk("v3_zre", v, -26);
    show(1, v); chk("v3_yim", v, 0);

    bus.cal_en      = 1'b1;
    bus.display_Rey = 1'b1;
    Rst             = 1'b1;
    tick();
    Rst = 1'b0;
    clr();
    chk("rst2_out", int'($signed(bus.out)), 0);
    chk("rst2_ovf", int'(bus.ovf), 0);
    show(0, v); chk("rst2_yre", v, 0);
    show(2, v); chk("rst2_zre", v, 0);

    bus.mul_en = 1'b1; tick(); clr();
    bus.cal_en = 1'b1; tick(); clr();
    show(0, v); chk("rerun_yre", v, 0);
    show(3, v); chk("rerun_zim", v, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
